// File: rtl/mul_pipe_if.sv
// mul_pipe_if -- request/result bus of the two-stage multiplier.
//   master : upstream/downstream side (drives operations, consumes results)
//   slave  : the multiplier itself
// Signals:
//   in_valid/in_ready            operation handshake
//   in_op, in_src1, in_src2      opcode and 32-bit operands
//   in_tag                       destination tag, echoed on out_tag
//   out_valid/out_ready          result handshake
//   out_result, out_tag          32-bit result word and its tag
interface mul_pipe_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe -- two-stage pipelined 32x32 multiplier (mul.w / mulh.w / mulh.wu).
//   S1 registers operands, op and tag; a radix-4 Booth multiplier forms the
//   64-bit product from S1; S2 registers product, op and tag and drives the
//   result bus. Valid/ready on both sides, flush discards in-flight work.
// Ports:
//   mul_clk    clock, rising edge
//   resetn     asynchronous active-low reset
//   bus        mul_pipe_if.slave (in_* request, out_* result)
//   flush      clears both stages; blocks acceptance in the same cycle
//   busy       S1 or S2 holds a valid operation
//   stall_cnt  (only with MUL_STALL_CNT_EN) cycles with out_valid & ~out_ready
// Optional feature macro: MUL_STALL_CNT_EN
module mul_pipe #(
  parameter int TAG_W = 5
) (
  input  logic        mul_clk,
  input  logic        resetn,
  mul_pipe_if.slave   bus,
  input  logic        flush,
`ifdef MUL_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        busy
);

  localparam int NUM_PP = 17;  // radix-4 digits covering a 34-bit multiplier

  logic             s1_valid_reg;
  logic [1:0]       s1_op_reg;
  logic [31:0]      s1_src1_reg;
  logic [31:0]      s1_src2_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [1:0]       s2_op_reg;
  logic [63:0]      s2_product_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv       = ~s2_valid_reg | bus.out_ready;
  assign s1_adv       = s1_valid_reg & s2_adv;
  assign bus.in_ready = ~flush & (~s1_valid_reg | s1_adv);
  assign in_fire      = bus.in_valid & bus.in_ready;

  // ---------------------------------------------------------------------
  // Booth multiplier. Operands are widened to 33 bits (sign- or zero-
  // extended by mode) so one signed datapath covers both signed and
  // unsigned products; only the low 64 bits of the sum are kept.
  // ---------------------------------------------------------------------
  logic        signed_mode;
  logic [32:0] mcand_33;
  logic [32:0] mplier_33;
  logic [63:0] mcand;
  logic [34:0] mplier;  // {sign ext, 33-bit multiplier, implicit b[-1]=0}
  logic [63:0] pp [NUM_PP];
  logic [63:0] product;

  assign signed_mode = (s1_op_reg != 2'b10);
  assign mcand_33    = {signed_mode & s1_src1_reg[31], s1_src1_reg};
  assign mplier_33   = {signed_mode & s1_src2_reg[31], s1_src2_reg};
  assign mcand       = {{31{mcand_33[32]}}, mcand_33};
  assign mplier      = {mplier_33[32], mplier_33, 1'b0};

  function automatic logic [63:0] booth_pp(input logic [2:0] trip, input logic [63:0] m);
    case (trip)
      3'b001, 3'b010: return m;
      3'b011:         return m << 1;
      3'b100:         return -(m << 1);
      3'b101, 3'b110: return -m;
      default:        return '0;
    endcase
  endfunction

  for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
    assign pp[gi] = booth_pp(mplier[2*gi+2:2*gi], mcand) << (2 * gi);
  end

  always_comb begin
    product = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      product = product + pp[i];
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg   <= 1'b0;
      s1_op_reg      <= '0;
      s1_src1_reg    <= '0;
      s1_src2_reg    <= '0;
      s1_tag_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_op_reg      <= '0;
      s2_product_reg <= '0;
      s2_tag_reg     <= '0;
    end else if (flush) begin
      // A result shown during flush is dropped even if out_ready is high.
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_product_reg <= product;
          s2_op_reg      <= s1_op_reg;
          s2_tag_reg     <= s1_tag_reg;
        end
      end
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_op_reg    <= bus.in_op;
        s1_src1_reg  <= bus.in_src1;
        s1_src2_reg  <= bus.in_src2;
        s1_tag_reg   <= bus.in_tag;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // High word for the mulh variants, low word for mul.w and the reserved op.
  assign bus.out_result = (s2_op_reg == 2'b01 || s2_op_reg == 2'b10)
                          ? s2_product_reg[63:32] : s2_product_reg[31:0];
  assign bus.out_tag    = s2_tag_reg;
  assign bus.out_valid  = s2_valid_reg;
  assign busy           = s1_valid_reg | s2_valid_reg;

`ifdef MUL_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Free-running, wraps naturally; flush does not touch it.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_reg <= '0;
    end else if (s2_valid_reg && !bus.out_ready) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
